uart_poll_ctrl: RTL and testbench
=================================

UART_POLL_CTRL -- requirements
Module: uart_poll_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: UART MMIO base; RX data at +0, TX data at +4, status at +8.
REQ-002 SHALL have parameter TX_DEPTH, default 8: TX FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of two, >=2.
REQ-004 i_clk  input  1  clock, all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_tx_valid  input  1  producer offers TX byte.
REQ-007 i_tx_data  input  8  TX byte.
REQ-008 o_tx_ready  output  1  TX FIFO not full.
REQ-009 o_rx_valid  output  1  RX FIFO not empty.
REQ-010 o_rx_data  output  8  RX FIFO head byte.
REQ-011 i_rx_ready  input  1  consumer takes RX byte.
REQ-012 o_rx_overflow  output  1  one-cycle pulse, received byte dropped.
REQ-013 o_mmio_addr  output  32  MMIO address to UART.
REQ-014 o_mmio_data  output  8  MMIO write data.
REQ-015 o_mmio_we / o_mmio_re  output  1 each  MMIO write / read strobes.
REQ-016 i_mmio_data  input  8  MMIO read data, registered: valid the cycle after o_mmio_re.

Function
REQ-017 SHALL transfer a TX byte when i_tx_valid && o_tx_ready; a byte leaves RX FIFO when o_rx_valid && i_rx_ready; simultaneous push/pop on the same FIFO SHALL both occur, level unchanged.
REQ-018 FIFO pointers SHALL wrap modulo depth; full/empty from a count one bit wider than the pointer.
REQ-019 FSM states: POLL, EVAL, RX_RD, RX_CAP, TX_WR, TX_HOLD.
REQ-020 POLL: o_mmio_re=1, o_mmio_addr=BASE_ADDR+8; next EVAL.
REQ-021 EVAL: sample status (bit0 rx_valid, bit1 tx_busy); rx_prev <= bit0; priority order: (a) bit0=1 and rx_prev=0 -> RX_RD; (b) TX FIFO non-empty and bit1=0 -> TX_WR; (c) else POLL.
REQ-022 RX_RD: o_mmio_re=1, o_mmio_addr=BASE_ADDR; next RX_CAP.
REQ-023 RX_CAP: push i_mmio_data into RX FIFO if not full, else drop it and pulse o_rx_overflow; next POLL.
REQ-024 TX_WR: o_mmio_we=1, o_mmio_addr=BASE_ADDR+4, o_mmio_data=TX head, pop TX FIFO same cycle; next TX_HOLD.
REQ-025 TX_HOLD: SHALL last exactly 2 cycles (lets UART busy assert) with no strobes; next POLL.
REQ-026 Outside active states o_mmio_we, o_mmio_re SHALL be 0, o_mmio_addr and o_mmio_data 0; we and re never both 1.
REQ-027 Minimum status-to-write latency: 2 cycles (POLL, EVAL) from a TX byte reaching an idle FIFO while FSM is in POLL.
REQ-028 One MMIO write per TX byte; bytes SHALL leave in push order.

Reset
REQ-029 On !i_rst: FSM=POLL, FIFOs empty, rx_prev=0, hold counter 0; o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_rx_overflow=0, MMIO outputs 0 (re asserts on first active cycle).
REQ-030 Reset mid-operation SHALL discard all buffered bytes and any in-flight read/write without completing it.

Structure
REQ-031 Package uart_pkg SHALL hold register offsets (0, 4, 8), status bit indices, and the FSM state enum.
REQ-032 One sub-module uart_byte_fifo (parameter DEPTH, push/pop/full/empty/head), instantiated for TX and RX.

Verification
REQ-033 Reset, then push 8'h41 with status reads 8'h00 -> POLL, EVAL, TX_WR with addr 32'h1000_0004, data 8'h41, we one cycle.
REQ-034 Push 8'h31,8'h32,8'h33 while model holds tx_busy=1 for 20 cycles -> no we until busy=0, then three writes in order, each preceded by 2-cycle hold and a status poll.
REQ-035 Status bit0 rises, RX reg = 8'h5A -> re at 32'h1000_0000, o_rx_valid=1 with o_rx_data=8'h5A; bit0 held high -> no second capture until it falls and rises.
REQ-036 RX_DEPTH=8, i_rx_ready=0, nine RX events -> FIFO holds first 8, ninth pulses o_rx_overflow once.
REQ-037 RX event and TX pending in same EVAL (status 8'h01) -> RX read first, TX write on following round.
REQ-038 Assert i_rst during TX_HOLD with 3 bytes queued -> outputs at reset values, o_tx_ready=1, no further we.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the polled UART controller: register map, status
// bit positions and the polling FSM state encoding.
package uart_pkg;

    localparam logic [31:0] REG_RX_OFF   = 32'h0;
    localparam logic [31:0] REG_TX_OFF   = 32'h4;
    localparam logic [31:0] REG_STAT_OFF = 32'h8;

    localparam int STAT_RX_VALID_BIT = 0;
    localparam int STAT_TX_BUSY_BIT  = 1;

    typedef enum logic [2:0] {
        ST_POLL    = 3'd0,
        ST_EVAL    = 3'd1,
        ST_RX_RD   = 3'd2,
        ST_RX_CAP  = 3'd3,
        ST_TX_WR   = 3'd4,
        ST_TX_HOLD = 3'd5
    } state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two so pointers wrap
// naturally. Push when full and pop when empty are ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: empty/full and the pointers gate every read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_poll_ctrl.sv
// Polled UART MMIO controller: buffers producer TX bytes and received RX
// bytes, and services the UART by repeatedly reading its status register.
//
// Handshakes: a TX byte transfers on a cycle where i_tx_valid && o_tx_ready;
// an RX byte leaves on a cycle where o_rx_valid && i_rx_ready. Both sides may
// transfer in the same cycle. o_state exposes the polling FSM for debug.
module uart_poll_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tx_valid,
    input  logic [7:0]  i_tx_data,
    output logic        o_tx_ready,
    output logic        o_rx_valid,
    output logic [7:0]  o_rx_data,
    input  logic        i_rx_ready,
    output logic        o_rx_overflow,
    output logic [31:0] o_mmio_addr,
    output logic [7:0]  o_mmio_data,
    output logic        o_mmio_we,
    output logic        o_mmio_re,
    input  logic [7:0]  i_mmio_data,
    output state_t      o_state
);

    state_t     state;
    logic       rx_prev;
    logic       hold_cnt;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       tx_pop;
    logic       rx_push;

    assign tx_pop  = (state == ST_TX_WR);
    assign rx_push = (state == ST_RX_CAP);

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (i_tx_valid),
        .push_data (i_tx_data),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (rx_push),
        .push_data (i_mmio_data),
        .pop       (i_rx_ready),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    assign o_tx_ready    = !tx_full;
    assign o_rx_valid    = !rx_empty;
    assign o_rx_data     = rx_empty ? 8'h00 : rx_head;
    assign o_rx_overflow = (state == ST_RX_CAP) && rx_full;
    assign o_state       = state;

    // MMIO outputs are loaded on entry to the state that owns them, so they are
    // valid for exactly that state's cycles and zero everywhere else.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_POLL;
            rx_prev     <= 1'b0;
            hold_cnt    <= 1'b0;
            o_mmio_re   <= 1'b0;
            o_mmio_we   <= 1'b0;
            o_mmio_addr <= '0;
            o_mmio_data <= '0;
        end else begin
            o_mmio_re   <= 1'b0;
            o_mmio_we   <= 1'b0;
            o_mmio_addr <= '0;
            o_mmio_data <= '0;
            case (state)
                ST_POLL: begin
                    // Coming out of reset the status read has not been issued yet.
                    if (!o_mmio_re) begin
                        o_mmio_re   <= 1'b1;
                        o_mmio_addr <= BASE_ADDR + REG_STAT_OFF;
                    end else begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    rx_prev <= i_mmio_data[STAT_RX_VALID_BIT];
                    if (i_mmio_data[STAT_RX_VALID_BIT] && !rx_prev) begin
                        state       <= ST_RX_RD;
                        o_mmio_re   <= 1'b1;
                        o_mmio_addr <= BASE_ADDR + REG_RX_OFF;
                    end else if (!tx_empty && !i_mmio_data[STAT_TX_BUSY_BIT]) begin
                        state       <= ST_TX_WR;
                        o_mmio_we   <= 1'b1;
                        o_mmio_addr <= BASE_ADDR + REG_TX_OFF;
                        o_mmio_data <= tx_head;
                    end else begin
                        state       <= ST_POLL;
                        o_mmio_re   <= 1'b1;
                        o_mmio_addr <= BASE_ADDR + REG_STAT_OFF;
                    end
                end
                ST_RX_RD: begin
                    state <= ST_RX_CAP;
                end
                ST_RX_CAP: begin
                    state       <= ST_POLL;
                    o_mmio_re   <= 1'b1;
                    o_mmio_addr <= BASE_ADDR + REG_STAT_OFF;
                end
                ST_TX_WR: begin
                    state    <= ST_TX_HOLD;
                    hold_cnt <= 1'b0;
                end
                ST_TX_HOLD: begin
                    if (hold_cnt) begin
                        state       <= ST_POLL;
                        hold_cnt    <= 1'b0;
                        o_mmio_re   <= 1'b1;
                        o_mmio_addr <= BASE_ADDR + REG_STAT_OFF;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_POLL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_poll_ctrl.sv
// Directed bench for uart_poll_ctrl with a small registered UART register model.
module tb_uart_poll_ctrl;
    import uart_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_tx_valid = 1'b0;
    logic [7:0]  i_tx_data = 8'h00;
    logic        o_tx_ready;
    logic        o_rx_valid;
    logic [7:0]  o_rx_data;
    logic        i_rx_ready = 1'b0;
    logic        o_rx_overflow;
    logic [31:0] o_mmio_addr;
    logic [7:0]  o_mmio_data;
    logic        o_mmio_we;
    logic        o_mmio_re;
    logic [7:0]  i_mmio_data = 8'h00;
    state_t      o_state;

    uart_poll_ctrl #(.BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_tx_valid    (i_tx_valid),
        .i_tx_data     (i_tx_data),
        .o_tx_ready    (o_tx_ready),
        .o_rx_valid    (o_rx_valid),
        .o_rx_data     (o_rx_data),
        .i_rx_ready    (i_rx_ready),
        .o_rx_overflow (o_rx_overflow),
        .o_mmio_addr   (o_mmio_addr),
        .o_mmio_data   (o_mmio_data),
        .o_mmio_we     (o_mmio_we),
        .o_mmio_re     (o_mmio_re),
        .i_mmio_data   (i_mmio_data),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ovf_cnt = 0;
    int last_rd_cyc = 0;
    int wr_cyc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] stat_reg = 8'h00;
    logic [7:0] rx_reg = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART register model: read data appears the cycle after the read strobe.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mmio_re)
            i_mmio_data <= (o_mmio_addr == BASE + 32'h8) ? stat_reg : rx_reg;
    end

    // Scoreboard: every MMIO write must carry the oldest outstanding TX byte.
    always @(negedge i_clk) begin
        if (i_rst) begin
            check("re_we_exclusive", {31'b0, o_mmio_re && o_mmio_we}, 32'h0);
            if (o_mmio_we) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                check("wr_addr", o_mmio_addr, BASE + 32'h4);
                check("wr_data", {24'h0, o_mmio_data},
                      (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD_BEEF);
            end
            if (o_mmio_re && o_mmio_addr == BASE) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (o_rx_overflow) ovf_cnt++;
        end
    end

    task automatic push_tx(input logic [7:0] b);
        i_tx_valid = 1'b1;
        i_tx_data  = b;
        exp_q.push_back(b);
        @(negedge i_clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        i_rx_ready = 1'b1;
        @(negedge i_clk);
        i_rx_ready = 1'b0;
    endtask

    task automatic wait_state(input state_t s);
        for (int i = 0; i < 40 && o_state != s; i++) @(negedge i_clk);
    endtask

    initial begin
        int wr0, rd0, ovf0, rdk, n;

        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_re", {31'b0, o_mmio_re}, 32'h0);
        check("rst_we", {31'b0, o_mmio_we}, 32'h0);
        check("rst_addr", o_mmio_addr, 32'h0);
        check("rst_data", {24'h0, o_mmio_data}, 32'h0);
        check("rst_tx_ready", {31'b0, o_tx_ready}, 32'h1);
        check("rst_rx_valid", {31'b0, o_rx_valid}, 32'h0);
        check("rst_rx_data", {24'h0, o_rx_data}, 32'h0);
        check("rst_ovf", {31'b0, o_rx_overflow}, 32'h0);
        check("rst_state", 32'(o_state), 32'(ST_POLL));

        // Single TX byte: POLL, EVAL, TX_WR, two holds, back to POLL
        i_rst = 1'b1;
        push_tx(8'h41);
        check("t1_poll_state", 32'(o_state), 32'(ST_POLL));
        check("t1_poll_re", {31'b0, o_mmio_re}, 32'h1);
        check("t1_poll_addr", o_mmio_addr, 32'h1000_0008);
        @(negedge i_clk);
        check("t1_eval_state", 32'(o_state), 32'(ST_EVAL));
        check("t1_eval_re", {31'b0, o_mmio_re}, 32'h0);
        @(negedge i_clk);
        check("t1_wr_state", 32'(o_state), 32'(ST_TX_WR));
        check("t1_wr_we", {31'b0, o_mmio_we}, 32'h1);
        check("t1_wr_addr", o_mmio_addr, 32'h1000_0004);
        check("t1_wr_data", {24'h0, o_mmio_data}, 32'h41);
        @(negedge i_clk);
        check("t1_hold1_state", 32'(o_state), 32'(ST_TX_HOLD));
        check("t1_hold1_we", {31'b0, o_mmio_we}, 32'h0);
        check("t1_hold1_addr", o_mmio_addr, 32'h0);
        @(negedge i_clk);
        check("t1_hold2_state", 32'(o_state), 32'(ST_TX_HOLD));
        @(negedge i_clk);
        check("t1_repoll_state", 32'(o_state), 32'(ST_POLL));
        check("t1_repoll_re", {31'b0, o_mmio_re}, 32'h1);
        check("t1_wr_count", wr_cnt, 32'd1);

        // TX blocked by busy, then three ordered writes with fixed spacing
        stat_reg = 8'h02;
        wr0 = wr_cnt;
        push_tx(8'h31);
        push_tx(8'h32);
        push_tx(8'h33);
        repeat (20) @(negedge i_clk);
        check("t2_busy_no_write", wr_cnt, wr0);
        stat_reg = 8'h00;
        for (int i = 0; i < 60 && wr_cnt < wr0 + 3; i++) @(negedge i_clk);
        check("t2_write_count", wr_cnt, wr0 + 3);
        n = wr_cyc_q.size();
        check("t2_gap_2", wr_cyc_q[n-2] - wr_cyc_q[n-3], 32'd5);
        check("t2_gap_3", wr_cyc_q[n-1] - wr_cyc_q[n-2], 32'd5);
        check("t2_exp_drained", exp_q.size(), 32'd0);

        // RX capture on rising rx_valid, none while it stays high
        repeat (4) @(negedge i_clk);
        rd0 = rd_cnt;
        rx_reg = 8'h5A;
        stat_reg = 8'h01;
        for (int i = 0; i < 30 && !o_rx_valid; i++) @(negedge i_clk);
        check("t3_rx_valid", {31'b0, o_rx_valid}, 32'h1);
        check("t3_rx_data", {24'h0, o_rx_data}, 32'h5A);
        check("t3_rd_count", rd_cnt, rd0 + 1);
        repeat (20) @(negedge i_clk);
        check("t3_no_recapture", rd_cnt, rd0 + 1);
        pop_rx();
        check("t3_rx_empty", {31'b0, o_rx_valid}, 32'h0);
        check("t3_rx_data_zero", {24'h0, o_rx_data}, 32'h0);
        stat_reg = 8'h00;
        repeat (6) @(negedge i_clk);
        rx_reg = 8'hA5;
        stat_reg = 8'h01;
        for (int i = 0; i < 30 && !o_rx_valid; i++) @(negedge i_clk);
        check("t3_second_data", {24'h0, o_rx_data}, 32'hA5);
        check("t3_second_count", rd_cnt, rd0 + 2);
        pop_rx();
        stat_reg = 8'h00;
        repeat (6) @(negedge i_clk);

        // Nine RX events into an 8-deep FIFO: exactly one overflow
        ovf0 = ovf_cnt;
        for (int k = 0; k < 9; k++) begin
            rx_reg = 8'h10 + 8'(k);
            stat_reg = 8'h01;
            rdk = rd_cnt;
            for (int i = 0; i < 20 && rd_cnt == rdk; i++) @(negedge i_clk);
            repeat (2) @(negedge i_clk);
            check("t4_rx_event", rd_cnt, rdk + 1);
            stat_reg = 8'h00;
            repeat (6) @(negedge i_clk);
        end
        check("t4_overflow_once", ovf_cnt, ovf0 + 1);
        for (int k = 0; k < 8; k++) begin
            check("t4_drain_valid", {31'b0, o_rx_valid}, 32'h1);
            check("t4_drain_data", {24'h0, o_rx_data}, 32'h10 + 32'(k));
            pop_rx();
        end
        check("t4_drained_empty", {31'b0, o_rx_valid}, 32'h0);

        // RX event and pending TX in the same EVAL: read wins, write next round
        wait_state(ST_POLL);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        stat_reg = 8'h01;
        rx_reg = 8'h77;
        push_tx(8'h99);
        for (int i = 0; i < 20 && wr_cnt == wr0; i++) @(negedge i_clk);
        check("t5_write_done", wr_cnt, wr0 + 1);
        check("t5_read_done", rd_cnt, rd0 + 1);
        check("t5_rd_then_wr", wr_cyc_q[wr_cyc_q.size()-1] - last_rd_cyc, 32'd4);
        check("t5_rx_data", {24'h0, o_rx_data}, 32'h77);
        pop_rx();
        stat_reg = 8'h00;
        repeat (6) @(negedge i_clk);

        // Reset during TX_HOLD with three bytes still queued
        wait_state(ST_POLL);
        push_tx(8'hAA);
        push_tx(8'hBB);
        push_tx(8'hCC);
        push_tx(8'hDD);
        check("t6_in_hold", 32'(o_state), 32'(ST_TX_HOLD));
        i_rst = 1'b0;
        #1;
        exp_q.delete();
        wr0 = wr_cnt;
        check("t6_rst_state", 32'(o_state), 32'(ST_POLL));
        check("t6_rst_re", {31'b0, o_mmio_re}, 32'h0);
        check("t6_rst_we", {31'b0, o_mmio_we}, 32'h0);
        check("t6_rst_addr", o_mmio_addr, 32'h0);
        check("t6_rst_data", {24'h0, o_mmio_data}, 32'h0);
        check("t6_rst_tx_ready", {31'b0, o_tx_ready}, 32'h1);
        check("t6_rst_rx_valid", {31'b0, o_rx_valid}, 32'h0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (30) @(negedge i_clk);
        check("t6_no_more_writes", wr_cnt, wr0);
        check("t6_tx_ready", {31'b0, o_tx_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
